// File: rtl/pe_chain_io.sv
`default_nettype none
// ============================================================================
// Module  : pe_chain_io
// Brief   : Host-side boundary streamer and solution-chain collector for one
//           row of bit-serial Jacobi PEs.
// Revision: 1.0 - initial release
// ============================================================================
module pe_chain_io #(
   parameter int WIDTH  = 8,
   parameter int N_PE   = 4,
   parameter int ITER_W = 16,
   localparam int c_BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1,
   localparam int c_IW  = (N_PE > 1) ? $clog2(N_PE) : 1
) (
   input  logic              clka,
   input  logic              rst,
   input  logic              start,
   input  logic [ITER_W-1:0] iter_count,
   input  logic [WIDTH-1:0]  bnd_word,
   output logic              busy,
   output logic              done,
   output logic              mode_o,
   output logic              read_o,
   output logic              bnd_bit,
   input  logic              solution_in,
   output logic [WIDTH-1:0]  sol_data,
   output logic [c_IW-1:0]   sol_index,
   output logic              sol_valid,
   input  logic              sol_ready
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_READ    = 2'd2,
      S_FLUSH   = 2'd3
   } state_t;

   localparam logic [c_BW-1:0]   c_LAST_BIT  = c_BW'(WIDTH - 1);
   localparam logic [c_IW-1:0]   c_LAST_WORD = c_IW'(N_PE - 1);
   localparam logic [ITER_W-1:0] c_ITER_ONE  = ITER_W'(1);

   state_t            r_state;
   logic [ITER_W-1:0] r_iter;
   logic [WIDTH-1:0]  r_bnd;
   logic [c_BW-1:0]   r_bit;
   logic [c_IW-1:0]   r_word;
   logic [WIDTH-1:0]  r_shift;
   logic [c_BW-1:0]   w_bit_nxt;
   logic [WIDTH-1:0]  w_shift;
   logic              w_read;

   // The chain shift stalls in the very cycle a held word is not accepted.
   always_comb begin
      w_read           = (r_state == S_READ) && !(sol_valid && !sol_ready);
      w_bit_nxt        = r_bit + c_BW'(1);
      w_shift          = r_shift;
      w_shift[r_bit]   = solution_in;
   end

   assign read_o = w_read;

   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_iter    <= '0;
         r_bnd     <= '0;
         r_bit     <= '0;
         r_word    <= '0;
         r_shift   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mode_o    <= 1'b0;
         bnd_bit   <= 1'b0;
         sol_data  <= '0;
         sol_index <= '0;
         sol_valid <= 1'b0;
      end else begin
         done <= 1'b0;
         if (sol_valid && sol_ready) begin
            sol_valid <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_iter <= iter_count;
                  r_bnd  <= bnd_word;
                  r_bit  <= '0;
                  r_word <= '0;
                  busy   <= 1'b1;
                  if (iter_count != '0) begin
                     r_state <= S_COMPUTE;
                     mode_o  <= 1'b1;
                     bnd_bit <= bnd_word[0];
                  end else begin
                     r_state <= S_READ;
                  end
               end
            end
            S_COMPUTE: begin
               if (r_bit == c_LAST_BIT) begin
                  r_bit <= '0;
                  if (r_iter == c_ITER_ONE) begin
                     r_iter  <= '0;
                     mode_o  <= 1'b0;
                     bnd_bit <= 1'b0;
                     r_state <= S_READ;
                  end else begin
                     r_iter  <= r_iter - c_ITER_ONE;
                     bnd_bit <= r_bnd[0];
                  end
               end else begin
                  r_bit   <= w_bit_nxt;
                  bnd_bit <= r_bnd[w_bit_nxt];
               end
            end
            S_READ: begin
               if (w_read) begin
                  r_shift <= w_shift;
                  if (r_bit == c_LAST_BIT) begin
                     r_bit     <= '0;
                     sol_data  <= w_shift;
                     sol_index <= r_word;
                     sol_valid <= 1'b1;
                     if (r_word == c_LAST_WORD) begin
                        r_word  <= '0;
                        r_state <= S_FLUSH;
                     end else begin
                        r_word <= r_word + c_IW'(1);
                     end
                  end else begin
                     r_bit <= w_bit_nxt;
                  end
               end
            end
            S_FLUSH: begin
               if (sol_valid && sol_ready) begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
